systolic_seq_ctrl: RTL and testbench



---
 rtl/systolic_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for a ROWS x COLS weight-stationary systolic array: loads the stationary
// A matrix, streams N skewed B vectors, drains the array and pulses done.
module systolic_seq_ctrl #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int VEC_W = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [VEC_W-1:0]           num_vec_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [2*ROWS-1:0]          mux_o,
   output logic [ROWS-1:0]            add_zero_o,
   output logic                       w_rd_o,
   output logic [$clog2(ROWS)-1:0]    w_row_o,
   output logic [ROWS-1:0]            b_vld_o,
   output logic [VEC_W-1:0]           vec_idx_o,
   output logic [COLS-1:0]            out_vld_o
);

   localparam int RW   = $clog2(ROWS);
   // p must reach N_max+ROWS+COLS-2 without wrapping; CW adds headroom for window upper bounds
   localparam int PMAX = (2**VEC_W - 1) + ROWS + COLS - 2;
   localparam int PW   = $clog2(PMAX + 1);
   localparam int CW   = PW + 1;

   localparam logic [1:0] MUX_PASS = 2'd0;
   localparam logic [1:0] MUX_LOAD = 2'd1;
   localparam logic [1:0] MUX_PROC = 2'd2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_PROC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [RW-1:0]    t_q, t_d;
   logic [PW-1:0]    p_q, p_d;
   logic [VEC_W-1:0] n_q, n_d;

   logic          in_load, in_proc, load_last, proc_last;
   logic [CW-1:0] p_ext, n_ext;

   assign in_load   = (state_q == S_LOAD);
   assign in_proc   = (state_q == S_PROC);
   assign load_last = (t_q == RW'(ROWS - 1));
   assign p_ext     = {1'b0, p_q};
   assign n_ext     = CW'(n_q);
   assign proc_last = (p_ext == n_ext + CW'(ROWS + COLS - 2));

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      p_d     = p_q;
      n_d     = n_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               n_d     = num_vec_i;
               t_d     = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_last) begin
               p_d     = '0;
               state_d = (n_q != '0) ? S_PROC : S_DONE;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         S_PROC: begin
            if (proc_last) begin
               state_d = S_DONE;
            end else begin
               p_d = p_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         p_q     <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         p_q     <= p_d;
         n_q     <= n_d;
      end
   end

   // Outputs are decoded purely from registered state so start_i never reaches them combinationally.
   always_comb begin
      busy_o     = (state_q != S_IDLE);
      done_o     = (state_q == S_DONE);
      w_rd_o     = in_load;
      w_row_o    = in_load ? (RW'(ROWS - 1) - t_q) : '0;
      add_zero_o = '0;
      add_zero_o[0] = in_proc;
      vec_idx_o  = (in_proc && (p_ext < n_ext)) ? p_q[VEC_W-1:0] : '0;
      mux_o      = '0;
      b_vld_o    = '0;
      out_vld_o  = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (in_proc) begin
            mux_o[2*r +: 2] = MUX_PROC;
         end else if (in_load && load_last) begin
            mux_o[2*r +: 2] = MUX_LOAD;
         end else begin
            mux_o[2*r +: 2] = MUX_PASS;
         end
         // Row r sees vector k at p = k + r (left-edge skew)
         b_vld_o[r] = in_proc && (p_ext >= CW'(r)) && (p_ext < CW'(r) + n_ext);
      end
      for (int c = 0; c < COLS; c++) begin
         out_vld_o[c] = in_proc && (p_ext >= CW'(ROWS + c)) &&
                        (p_ext < CW'(ROWS + c) + n_ext);
      end
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: a timing model pushes expected outputs per cycle
// into a scoreboard queue which is popped and compared after each clock edge.
module tb_systolic_seq_ctrl;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int VEC_W = 8;
   localparam int RW    = $clog2(ROWS);
   localparam int OW    = 2 + 2*ROWS + ROWS + 1 + RW + ROWS + VEC_W + COLS;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic                start_i = 1'b0;
   logic [VEC_W-1:0]    num_vec_i = '0;
   logic                busy_o, done_o, w_rd_o;
   logic [2*ROWS-1:0]   mux_o;
   logic [ROWS-1:0]     add_zero_o, b_vld_o;
   logic [RW-1:0]       w_row_o;
   logic [VEC_W-1:0]    vec_idx_o;
   logic [COLS-1:0]     out_vld_o;

   systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .num_vec_i  (num_vec_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .mux_o      (mux_o),
      .add_zero_o (add_zero_o),
      .w_rd_o     (w_rd_o),
      .w_row_o    (w_row_o),
      .b_vld_o    (b_vld_o),
      .vec_idx_o  (vec_idx_o),
      .out_vld_o  (out_vld_o)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;
   int gcyc = 0;
   int job_start = 0;
   int done_rel = -1;
   int m_k = 0;
   int m_n = 0;
   logic [OW-1:0] sb_q[$];

   function automatic int done_cycle(input int n);
      return 1 + ROWS + ((n > 0) ? (n + ROWS + COLS - 1) : 0);
   endfunction

   // Expected outputs at cycle k of a job (k=0 means idle) with n vectors
   function automatic logic [OW-1:0] model_out(input int k, input int n);
      logic              busy, done, wrd;
      logic [2*ROWS-1:0] mux;
      logic [ROWS-1:0]   az, bv;
      logic [RW-1:0]     wrow;
      logic [VEC_W-1:0]  vi;
      logic [COLS-1:0]   ov;
      int t, p;
      busy = (k != 0); done = 1'b0; wrd = 1'b0; mux = '0; az = '0; bv = '0;
      wrow = '0; vi = '0; ov = '0;
      if (k >= 1 && k <= ROWS) begin
         t = k - 1;
         wrd = 1'b1;
         wrow = RW'(ROWS - 1 - t);
         if (t == ROWS - 1)
            for (int r = 0; r < ROWS; r++) mux[2*r +: 2] = 2'd1;
      end else if (k != 0 && k == done_cycle(n)) begin
         done = 1'b1;
      end else if (k != 0) begin
         p = k - ROWS - 1;
         for (int r = 0; r < ROWS; r++) begin
            mux[2*r +: 2] = 2'd2;
            bv[r] = (p >= r) && (p <= r + n - 1);
         end
         az[0] = 1'b1;
         vi = (p < n) ? VEC_W'(p) : '0;
         for (int c = 0; c < COLS; c++)
            ov[c] = (p >= ROWS + c) && (p <= ROWS + c + n - 1);
      end
      return {busy, done, mux, az, wrd, wrow, bv, vi, ov};
   endfunction

   task automatic step(input logic s, input int nv, input logic r);
      logic [OW-1:0] exp_v, obs_v;
      start_i   = s;
      num_vec_i = VEC_W'(nv);
      rst_i     = r;
      if (r) begin
         m_k = 0;
      end else if (m_k == 0) begin
         if (s) begin
            m_k = 1;
            m_n = nv;
         end
      end else begin
         m_k = m_k + 1;
         if (m_k > done_cycle(m_n)) m_k = 0;
      end
      sb_q.push_back(model_out(m_k, m_n));
      @(posedge clk_i);
      #1;
      gcyc++;
      exp_v = sb_q.pop_front();
      obs_v = {busy_o, done_o, mux_o, add_zero_o, w_rd_o, w_row_o, b_vld_o, vec_idx_o, out_vld_o};
      if (done_o) done_rel = gcyc - job_start;
      tests++;
      assert (obs_v === exp_v) else begin
         fails++;
         $error("FAIL outs cyc=%0d observed=%h expected=%h", gcyc - job_start, obs_v, exp_v);
      end
   endtask

   task automatic new_job(input int nv);
      job_start = gcyc;
      done_rel  = -1;
      step(1'b1, nv, 1'b0);
   endtask

   task automatic check_done(input string tag, input int want);
      tests++;
      assert (done_rel === want) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, done_rel, want);
      end
   endtask

   initial begin
      // Reset held two cycles; start during reset must lose
      step(1'b0, 0, 1'b1);
      step(1'b1, 3, 1'b1);
      repeat (2) step(1'b0, 0, 1'b0);

      // N=3 job: stray start in cycle 7 and in the DONE cycle 15, num_vec changes mid-job
      new_job(3);
      for (int c = 1; c <= 15; c++) step((c == 7) || (c == 15), (c == 7) ? 9 : 3, 1'b0);
      check_done("done_n3", 15);

      // Start in cycle 16 is accepted
      new_job(2);
      repeat (16) step(1'b0, 0, 1'b0);
      check_done("done_n2", 14);

      // N=0 skips PROCESS
      new_job(0);
      repeat (6) step(1'b0, 0, 1'b0);
      check_done("done_n0", 5);

      // Reset in cycle 9 abandons the job
      new_job(3);
      for (int c = 1; c <= 8; c++) step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      repeat (10) step(1'b0, 0, 1'b0);
      check_done("done_after_rst", -1);

      // Fresh job after reset
      new_job(1);
      repeat (14) step(1'b0, 0, 1'b0);
      check_done("done_n1", 13);

      // Maximum vector count exercises the full width of the process counter
      new_job(255);
      repeat (275) step(1'b0, 0, 1'b0);
      check_done("done_nmax", 267);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
